vid_scan: RTL and testbench

VID_SCAN -- requirements
Module: vid_scan

---
 rtl/vid_scan.sv | 80 ++++++++
 tb/tb_vid_scan.sv | 126 ++++++++++++
 2 files changed

// File: rtl/vid_scan.sv
// vid_scan: 1bpp raster scanner; fetches 32-pixel VRAM words ahead of display, LSB first.
// Optional frame interrupt on vbl when VID_FRAME_IRQ_EN is defined.
module vid_scan #(
  parameter int HACT = 1024,
  parameter int HFP = 24,
  parameter int HSW = 136,
  parameter int HBP = 160,
  parameter int VACT = 768,
  parameter int VFP = 3,
  parameter int VSW = 6,
  parameter int VBP = 29,
  parameter logic [15:0] BASE = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] adrb,
  input  logic [31:0] rdb,
  output logic        pix,
  output logic        de,
  output logic        hsync,
  output logic        vsync,
  output logic        vbl
);
  localparam int HTOTAL = HACT + HFP + HSW + HBP;
  localparam int VTOTAL = VACT + VFP + VSW + VBP;
  localparam int HW = $clog2(HTOTAL);
  localparam int VW = $clog2(VTOTAL);
  localparam logic [HW-1:0] H_LAST = HW'(HTOTAL - 1);
  localparam logic [HW-1:0] H_ACT = HW'(HACT);
  localparam logic [HW-1:0] H_ACT1 = HW'(HACT - 1);
  localparam logic [HW-1:0] HS_B = HW'(HACT + HFP);
  localparam logic [HW-1:0] HS_E = HW'(HACT + HFP + HSW);
  localparam logic [VW-1:0] V_LAST = VW'(VTOTAL - 1);
  localparam logic [VW-1:0] V_ACT = VW'(VACT);
  localparam logic [VW-1:0] V_ACT1 = VW'(VACT - 1);
  localparam logic [VW-1:0] VS_B = VW'(VACT + VFP);
  localparam logic [VW-1:0] VS_E = VW'(VACT + VFP + VSW);
  logic [HW-1:0] hcnt, hn;
  logic [VW-1:0] vcnt, vn;
  logic [31:0] sh;
  logic act, load, fetch_w, fetch_0, fetch_f;
  // Fetch decisions look at the next position so adrb is valid during the fetch cycle itself.
  always_comb begin
    hn = hcnt == H_LAST ? '0 : hcnt + HW'(1);
    vn = hcnt != H_LAST ? vcnt : vcnt == V_LAST ? '0 : vcnt + VW'(1);
    act = hcnt < H_ACT && vcnt < V_ACT;
    load = act && hcnt[4:0] == 5'd0;
    fetch_w = hn < H_ACT1 && hn[4:0] == 5'd31 && vn < V_ACT;
    fetch_0 = hn == H_LAST && vn < V_ACT1;
    fetch_f = hn == H_LAST && vn == V_LAST;
  end
  // Words are read strictly in address order, so every fetch except the frame's first is adrb+1.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      hcnt <= H_LAST;
      vcnt <= V_LAST;
      adrb <= BASE;
      sh <= '0;
      pix <= 1'b0;
      de <= 1'b0;
      hsync <= 1'b1;
      vsync <= 1'b1;
    end else begin
      hcnt <= hn;
      vcnt <= vn;
      adrb <= fetch_f ? BASE : (fetch_0 || fetch_w) ? adrb + 16'd1 : adrb;
      sh <= load ? {1'b0, rdb[31:1]} : sh >> 1;
      pix <= load ? rdb[0] : act & sh[0];
      de <= act;
      hsync <= !(hcnt >= HS_B && hcnt < HS_E);
      vsync <= !(vcnt >= VS_B && vcnt < VS_E);
    end
`ifdef VID_FRAME_IRQ_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) vbl <= 1'b0;
    else vbl <= hcnt == '0 && vcnt == V_ACT;
`else
  assign vbl = 1'b0;
`endif
endmodule

// File: tb/tb_vid_scan.sv
// tb_vid_scan: randomized-VRAM scoreboard bench for vid_scan on a reduced raster.
module tb_vid_scan;
  localparam int HACT = 64, HFP = 4, HSW = 6, HBP = 6;
  localparam int VACT = 5, VFP = 1, VSW = 2, VBP = 2;
  localparam int HT = HACT + HFP + HSW + HBP;
  localparam int VT = VACT + VFP + VSW + VBP;
  localparam int FR = HT * VT;
  localparam int W = HACT / 32;
  localparam logic [15:0] BASE = 16'hFFF8;
`ifdef VID_FRAME_IRQ_EN
  localparam bit IRQ = 1'b1;
`else
  localparam bit IRQ = 1'b0;
`endif
  typedef struct packed {
    logic pix, de, hs, vs, vbl;
    logic [15:0] adr;
  } exp_t;
  logic clk = 1'b0, rst;
  logic [15:0] adrb;
  logic [31:0] rdb;
  logic pix, de, hsync, vsync, vbl;
  logic [31:0] mem [65536];
  exp_t q[$];
  int checks = 0, fails = 0;
  int n = 0, idx = 0, de_c = 0, hs_c = 0, vs_c = 0, vb_c = 0;
  bit running = 1'b0;
  logic [15:0] last;
  vid_scan #(.HACT(HACT), .HFP(HFP), .HSW(HSW), .HBP(HBP), .VACT(VACT), .VFP(VFP),
    .VSW(VSW), .VBP(VBP), .BASE(BASE)) dut (
    .clk(clk), .rst(rst), .adrb(adrb), .rdb(rdb), .pix(pix), .de(de),
    .hsync(hsync), .vsync(vsync), .vbl(vbl));
  always #5 clk = ~clk;
  always @(posedge clk) rdb <= mem[adrb];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_adrb"}, 32'(adrb), 32'(BASE));
    chk({tag, "_pix"}, 32'(pix), 0);
    chk({tag, "_de"}, 32'(de), 0);
    chk({tag, "_hsync"}, 32'(hsync), 1);
    chk({tag, "_vsync"}, 32'(vsync), 1);
    chk({tag, "_vbl"}, 32'(vbl), 0);
  endtask
  // Reference: position of cycle n after release is (n-1) mod FR in raster order.
  int p, x, y;
  logic [31:0] w;
  exp_t e;
  always @(posedge clk) if (running) begin
    p = (n + FR - 1) % FR;
    x = p % HT;
    y = p / HT;
    e.de = x < HACT && y < VACT;
    w = mem[16'(BASE + y * W + x / 32)];
    e.pix = e.de && w[x % 32];
    e.hs = !(x >= HACT + HFP && x < HACT + HFP + HSW);
    e.vs = !(y >= VACT + VFP && y < VACT + VFP + VSW);
    e.vbl = IRQ && x == 0 && y == VACT;
    p = (p + 1) % FR;
    x = p % HT;
    y = p / HT;
    if (x % 32 == 31 && x < HACT - 1 && y < VACT) last = 16'(BASE + y * W + (x + 1) / 32);
    else if (x == HT - 1 && y < VACT - 1) last = 16'(BASE + (y + 1) * W);
    else if (x == HT - 1 && y == VT - 1) last = BASE;
    e.adr = last;
    q.push_back(e);
    n++;
  end
  exp_t g;
  always @(negedge clk) if (q.size() > 0) begin
    g = q.pop_front();
    chk("pix", 32'(pix), 32'(g.pix));
    chk("de", 32'(de), 32'(g.de));
    chk("hsync", 32'(hsync), 32'(g.hs));
    chk("vsync", 32'(vsync), 32'(g.vs));
    chk("vbl", 32'(vbl), 32'(g.vbl));
    chk("adrb", 32'(adrb), 32'(g.adr));
    de_c += int'(de);
    hs_c += int'(!hsync);
    vs_c += int'(!vsync);
    vb_c += int'(vbl);
    if (++idx == FR) begin
      chk("frame_de_count", de_c, HACT * VACT);
      chk("frame_hsync_low", hs_c, HSW * VT);
      chk("frame_vsync_low", vs_c, VSW * HT);
      chk("frame_vbl_count", vb_c, int'(IRQ));
      idx = 0; de_c = 0; hs_c = 0; vs_c = 0; vb_c = 0;
    end
  end
  task automatic release_rst();
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    last = BASE;
    idx = 0; de_c = 0; hs_c = 0; vs_c = 0; vb_c = 0;
    running = 1'b1;
    #1 chk("first_adrb", 32'(adrb), 32'(BASE));
  endtask
  initial begin
    rst = 1'b1;
    for (int i = 0; i < 65536; i++) mem[i] = $urandom;
    mem[BASE] = 32'h0000_0005;
    repeat (3) @(posedge clk);
    #1 chk_reset("rst0");
    release_rst();
    repeat (2 * FR + 2 * HT + 31) @(posedge clk);
    #2 chk("de_before_midreset", 32'(de), 1);
    rst = 1'b1;
    running = 1'b0;
    q.delete();
    #1 chk_reset("rst_mid");
    for (int i = 0; i < VACT * W; i++) mem[16'(BASE + i)] = $urandom;
    repeat (3) @(posedge clk);
    #1 chk_reset("rst_hold");
    release_rst();
    repeat (2 * FR + 5) @(posedge clk);
    @(negedge clk);
    #1 $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
